// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold limit and dead turnaround cycles.
// All outputs are registered; drive_en is one-hot or zero.
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] drive_en,
  output logic [2:0]      owner_id,
  output logic            grant_valid,
  output logic            timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  localparam logic [7:0]      HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [3:0]      TURN_LAST = 4'(TURN_CYC);
  localparam logic [NREQ-1:0] ONE       = NREQ'(1);
  localparam logic [2:0]      LAST_RST  = 3'(NREQ - 1);

  state_t          state_q, state_d;
  logic [NREQ-1:0] drive_en_q, drive_en_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      last_q, last_d;
  logic            gv_q, gv_d;
  logic            to_q, to_d;
  logic [7:0]      hold_q, hold_d;
  logic [3:0]      turn_q, turn_d;

  logic [2:0]      win_c;
  logic            found_c;
  int              idx_c;
  logic            own_req_c;
  logic            arb_c;

  // Search upward from last_owner+1 so the previous owner ranks last.
  always_comb begin
    win_c   = last_q;
    found_c = 1'b0;
    idx_c   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_c = int'(last_q) + i;
      if (idx_c >= NREQ) idx_c = idx_c - NREQ;
      if (!found_c && (((req >> idx_c) & ONE) != '0)) begin
        found_c = 1'b1;
        win_c   = 3'(idx_c);
      end
    end
  end

  assign own_req_c = |(req & drive_en_q);
  assign arb_c     = (state_q == IDLE) ||
                     ((state_q == TURN) && (turn_q == TURN_LAST));

  always_comb begin
    state_d    = state_q;
    drive_en_d = drive_en_q;
    owner_d    = owner_q;
    last_d     = last_q;
    gv_d       = gv_q;
    to_d       = 1'b0;
    hold_d     = hold_q;
    turn_d     = turn_q;

    unique case (state_q)
      IDLE: ;
      GRANT: begin
        if (!own_req_c || (hold_q == HOLD_MAX)) begin
          // A release wins over a simultaneous hold expiry.
          to_d       = own_req_c;
          state_d    = TURN;
          drive_en_d = '0;
          gv_d       = 1'b0;
          hold_d     = 8'd0;
          turn_d     = 4'd1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        if (turn_q != TURN_LAST) turn_d = turn_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (arb_c) begin
      if (found_c) begin
        state_d    = GRANT;
        drive_en_d = ONE << win_c;
        owner_d    = win_c;
        last_d     = win_c;
        gv_d       = 1'b1;
        hold_d     = 8'd1;
        turn_d     = 4'd0;
      end else if (state_q == TURN) begin
        state_d = IDLE;
        turn_d  = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      drive_en_q <= '0;
      owner_q    <= 3'd0;
      last_q     <= LAST_RST;
      gv_q       <= 1'b0;
      to_q       <= 1'b0;
      hold_q     <= 8'd0;
      turn_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      drive_en_q <= drive_en_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      gv_q       <= gv_d;
      to_q       <= to_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
    end
  end

  assign drive_en    = drive_en_q;
  assign owner_id    = owner_q;
  assign grant_valid = gv_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks for bus_arbiter.
// NREQ=4, MAX_HOLD=8, TURN_CYC=1.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] drive_en;
  logic [2:0] owner_id;
  logic       grant_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NREQ(4),
    .MAX_HOLD(8),
    .TURN_CYC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .drive_en(drive_en),
    .owner_id(owner_id),
    .grant_valid(grant_valid),
    .timeout(timeout)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    step();
    total++;
    if (drive_en !== 4'b0000 || grant_valid !== 1'b0 ||
        timeout !== 1'b0 || owner_id !== 3'd0) begin
      bad++;
      $display("FAIL reset: de=%b gv=%b to=%b id=%0d want 0000/0/0/0",
               drive_en, grant_valid, timeout, owner_id);
    end
    rst = 1'b0;
    step();
    total++;
    if (drive_en !== 4'b0001 || owner_id !== 3'd0 || grant_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_prio: de=%b id=%0d gv=%b want 0001/0/1",
               drive_en, owner_id, grant_valid);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    int k;
    do_reset();
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      k   = r % 4;
      exp = 4'b0001 << k;
      for (int c = 1; c <= 8; c++) begin
        step();
        total++;
        if (drive_en !== exp || timeout !== 1'b0 ||
            owner_id !== 3'(k) || grant_valid !== 1'b1) begin
          bad++;
          $display("FAIL rot_grant r%0d c%0d: de=%b to=%b id=%0d want %b/0/%0d",
                   r, c, drive_en, timeout, owner_id, exp, k);
        end
      end
      step();
      total++;
      if (drive_en !== 4'b0000 || timeout !== 1'b1 ||
          grant_valid !== 1'b0 || owner_id !== 3'(k)) begin
        bad++;
        $display("FAIL rot_turn r%0d: de=%b to=%b gv=%b id=%0d want 0000/1/0/%0d",
                 r, drive_en, timeout, grant_valid, owner_id, k);
      end
    end
    req = 4'b0000;
    step();
    total++;
    if (drive_en !== 4'b0000 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL rot_idle: de=%b to=%b want 0000/0", drive_en, timeout);
    end
  endtask

  task automatic test_release();
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      step();
      total++;
      if (drive_en !== 4'b0001 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL rel_grant c%0d: de=%b to=%b want 0001/0",
                 c, drive_en, timeout);
      end
    end
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (drive_en !== 4'b0000 || timeout !== 1'b0 ||
          grant_valid !== 1'b0 || owner_id !== 3'd0) begin
        bad++;
        $display("FAIL rel_off c%0d: de=%b to=%b gv=%b id=%0d want 0000/0/0/0",
                 c, drive_en, timeout, grant_valid, owner_id);
      end
    end
    req = 4'b0011;
    step();
    total++;
    if (drive_en !== 4'b0010 || owner_id !== 3'd1) begin
      bad++;
      $display("FAIL rel_next: de=%b id=%0d want 0010/1", drive_en, owner_id);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      step();
      total++;
      if (drive_en !== 4'b0001) begin
        bad++;
        $display("FAIL sim_grant c%0d: de=%b want 0001", c, drive_en);
      end
    end
    req = 4'b0000;
    step();
    total++;
    if (drive_en !== 4'b0000 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL sim_release: de=%b to=%b want 0000/0", drive_en, timeout);
    end
    step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      step();
      total++;
      if (drive_en !== 4'b0100 || owner_id !== 3'd2) begin
        bad++;
        $display("FAIL mid_grant c%0d: de=%b id=%0d want 0100/2",
                 c, drive_en, owner_id);
      end
    end
    rst = 1'b1;
    step();
    total++;
    if (drive_en !== 4'b0000 || timeout !== 1'b0 ||
        grant_valid !== 1'b0 || owner_id !== 3'd0) begin
      bad++;
      $display("FAIL mid_rst: de=%b to=%b gv=%b id=%0d want 0000/0/0/0",
               drive_en, timeout, grant_valid, owner_id);
    end
    rst = 1'b0;
    step();
    total++;
    if (drive_en !== 4'b0100 || owner_id !== 3'd2) begin
      bad++;
      $display("FAIL mid_regrant: de=%b id=%0d want 0100/2", drive_en, owner_id);
    end
    req = 4'b1010;
    step();
    step();
    total++;
    if (drive_en !== 4'b1000 || owner_id !== 3'd3) begin
      bad++;
      $display("FAIL mid_rr: de=%b id=%0d want 1000/3", drive_en, owner_id);
    end
  endtask

  task automatic test_random();
    logic rst_prev;
    do_reset();
    rst_prev = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 49) == 0);
      step();
      total++;
      if (!$onehot0(drive_en) || (grant_valid !== (|drive_en)) ||
          (timeout && (|drive_en))) begin
        bad++;
        $display("FAIL rand_inv c%0d: de=%b gv=%b to=%b",
                 c, drive_en, grant_valid, timeout);
      end
      if (rst) begin
        total++;
        if (drive_en !== 4'b0000 || timeout !== 1'b0) begin
          bad++;
          $display("FAIL rand_rst c%0d: de=%b to=%b want 0000/0",
                   c, drive_en, timeout);
        end
      end
      rst_prev = rst;
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_release();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of bus requesters (2..8).
REQ-002 SHALL have parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner (1..255).
REQ-003 SHALL have parameter TURN_CYC, default 1, dead cycles between owners (1..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  NREQ  per-requester bus request, level-sensitive; bit 0 is the instruction buffer.
REQ-007 SHALL have port drive_en  output  NREQ  registered one-hot tri-state enable per driver; bit 0 feeds the instruction buffer's Ins_Buff.
REQ-008 SHALL have port owner_id  output  3  index of current owner; valid only while grant_valid=1.
REQ-009 SHALL have port grant_valid  output  1  high while some drive_en bit is high.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-011 SHALL implement states IDLE, GRANT, TURN.
REQ-012 SHALL drive at most one drive_en bit high in any cycle; all drive_en bits SHALL be 0 in IDLE and TURN.
REQ-013 SHALL, in IDLE with req!=0 at edge n, enter GRANT with drive_en[winner]=1 from cycle n+1 (one-cycle latency).
REQ-014 SHALL select the winner round-robin: first requesting index searching upward from last_owner+1, wrapping NREQ-1 -> 0.
REQ-015 SHALL update last_owner to the winner at each grant.
REQ-016 SHALL, in GRANT, keep the grant while req[owner]=1 and hold_cnt<MAX_HOLD; hold_cnt SHALL be 1 in the first grant cycle and increment each cycle.
REQ-017 SHALL, on req[owner]=0 sampled in GRANT, drop drive_en on the next cycle and enter TURN.
REQ-018 SHALL, when hold_cnt=MAX_HOLD with req[owner]=1, drop drive_en on the next cycle, enter TURN, and pulse timeout for that one cycle.
REQ-019 SHALL treat req[owner] falling in the same cycle hold_cnt reaches MAX_HOLD as a normal release (no timeout pulse).
REQ-020 SHALL ignore changes to non-owner req bits during GRANT.
REQ-021 SHALL remain in TURN for exactly TURN_CYC cycles, counted by turn_cnt.
REQ-022 SHALL, on the last TURN cycle, arbitrate as in REQ-014: if req!=0 enter GRANT (drive_en high the next cycle), else enter IDLE.
REQ-023 SHALL let a timed-out owner that still requests compete again at lowest round-robin priority.
REQ-024 SHALL hold owner_id at its last value when grant_valid=0.
REQ-025 SHALL derive all outputs from registers only (no combinational path from req to drive_en).

Reset
REQ-026 SHALL, on rst=1 at an edge, set state=IDLE, drive_en=0, grant_valid=0, timeout=0, owner_id=0, hold_cnt=0, turn_cnt=0, last_owner=NREQ-1.
REQ-027 SHALL, on rst asserted during GRANT or TURN, force drive_en=0 in the cycle after the edge with no TURN period and no timeout pulse.
REQ-028 SHALL ignore req while rst=1.

Verification
REQ-029 SHALL verify reset priority: rst, then req=4'b1111 at edge n -> drive_en=4'b0001, owner_id=0 at n+1.
REQ-030 SHALL verify rotation: req=4'b1111 held with MAX_HOLD=8 and TURN_CYC=1 -> owners 0,1,2,3,0, each 8 cycles with drive_en=1 and timeout pulsed after each, separated by one all-zero drive_en cycle.
REQ-031 SHALL verify release: req=4'b0001 for 3 cycles then 0 -> drive_en[0] high 3 cycles, then TURN for 1 cycle, then IDLE with no timeout.
REQ-032 SHALL verify the simultaneous-event case: req[owner] falls in the same cycle hold_cnt=MAX_HOLD -> timeout stays 0.
REQ-033 SHALL verify mid-grant reset: rst asserted in the 3rd grant cycle of owner 2 -> drive_en=0 in the next cycle, then req=4'b0100 -> owner 2 granted via the reset priority pointer.
REQ-034 SHALL verify the invariant: $onehot0(drive_en) in every cycle under 10k cycles of random req with random rst pulses.
